refill_arbiter: RTL and testbench
=================================

# refill_arbiter

Sequencer and arbiter for the single main-memory refill port of the instruction-cache subsystem. It accepts 8-byte block refill requests from two requesters, the instruction-cache miss path (port 0) and the next-line prefetcher (port 1). It grants them round-robin, drives the memory's miss/address inputs and waits for the memory's write strobe. It then returns the captured 64-bit block to the winner and bounds every access with a timeout.

## Interface
- `ADDR_W`, 32, request/memory address width
- `BLOCK_W`, 64, block width (8 bytes)
- `TIMEOUT`, 16, maximum cycles in WAIT before the access is abandoned (legal range ≥ 12)
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  icache refill request
- `req0_addr`  in  ADDR_W  icache refill byte address
- `req0_ready`  out  1  request 0 accepted this cycle
- `rsp0_valid`  out  1  one-cycle pulse, block/err for port 0 valid
- `req1_valid`, `req1_addr`, `req1_ready`, `rsp1_valid`: same meanings for the prefetcher
- `rsp_block`  out  BLOCK_W  returned block, shared by both ports
- `rsp_err`  out  1  qualifies rsp*_valid; 1 means timeout, block is 0
- `mem_miss`  out  1  access request to main memory, held for the whole access
- `mem_addr`  out  ADDR_W  block-aligned address to memory
- `mem_block`  in  BLOCK_W  memory data, valid while `mem_write`=1
- `mem_write`  in  1  memory completion strobe

## Operation
- Reset (async, immediate): state IDLE; all outputs 0; `last_grant`=1, so port 0 wins first; counter 0; in-flight access abandoned.
- Transactions: a request is accepted when `reqN_valid & reqN_ready`. The requester holds valid/addr stable until accepted.
- Block alignment: the latched address is `reqN_addr` with bits [2:0] forced to 0. `mem_addr` always shows the latched address.
- States:
  - IDLE: if any valid, pick the winner, pulse its `ready`, latch its aligned address and id, then go to WAIT. Both valid: grant the port ≠ `last_grant`. Update `last_grant` to the winner. `mem_write` is ignored here.
  - WAIT: `mem_miss`=1 and the counter increments each cycle.
    - `mem_write`=1 → capture `mem_block`, `err`=0, go to RESP.
    - Otherwise, if the counter reaches TIMEOUT-1 → `err`=1, block 0, go to RESP.
    - `mem_write` wins over the timeout if both occur in the same cycle.
  - RESP: `mem_miss`=0. Pulse `rsp<id>_valid` with `rsp_block`/`rsp_err`. Clear the counter and go to IDLE.
- Merge: in RESP, if the non-winning port is valid and its aligned address equals the latched address and `err`=0, that port is accepted too. Its `ready` pulses and both `rsp0_valid` and `rsp1_valid` pulse in the same cycle. `last_grant` is unchanged by a merge.
- `ready` is never asserted outside IDLE or a RESP merge. At most one `ready` is asserted per cycle in IDLE.
- `rsp_block`/`rsp_err` hold their value until the next RESP. The `rsp*_valid` pulses are zero outside RESP.

## Timing
- Accept at cycle T (IDLE). `mem_miss` rises at T+1. If `mem_write` is sampled high at cycle W, then RESP/`rsp_valid` occurs at W+1 and IDLE at W+2.
- With the team's 9-cycle main memory, `mem_write` arrives at T+10 and the response at T+11. Back-to-back requests then have a 12-cycle accept-to-accept spacing.
- Timeout: the first WAIT cycle is T+1. Without `mem_write`, RESP with `err` occurs at T+1+TIMEOUT.
- `mem_miss` deasserts in RESP. A late or lingering `mem_write` (memory holds its strobe one extra cycle) lands in RESP/IDLE and is ignored.
- Reset asserted in any state clears outputs without waiting for a clock edge. After release, the first accept occurs on the first edge with a valid request.

## Test plan
- Single request: `req0_addr`=0x0000_0013 at T, memory returns 0x1122334455667788 at T+10 → `mem_addr`=0x10 during T+1..T+10, `rsp0_valid` at T+11 with that block, `rsp_err`=0.
- Simultaneous requests: port 0 addr 0x20 and port 1 addr 0x40 valid in the same cycle after reset → port 0 served first. Port 1 is then accepted in the IDLE cycle after port 0's RESP.
- Round-robin fairness: both ports request continuously for 4 transactions → grant order 0,1,0,1.
- Merge: port 0 addr 0x48 in flight, port 1 raises addr 0x4C during WAIT → in RESP both `req1_ready` and `rsp0_valid`/`rsp1_valid` pulse with the same block, and `last_grant` stays 0.
- Timeout: TIMEOUT=16 and `mem_write` is never asserted → `rsp0_valid` and `rsp_err`=1 with block 0 at T+17, then IDLE. A stray `mem_write` at T+18 has no effect.
- Reset mid-WAIT: assert `reset` at T+5 → `mem_miss`, `ready` and `rsp` outputs are 0 immediately. No response is ever issued for that request, and the next request after release is granted to port 0.

Source files
------------

// File: rtl/refill_arbiter_if.sv
// Refill-port bundle: two requester handshakes, the shared response bus
// and the main-memory miss/strobe pair.
interface refill_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 64
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              rsp0_valid;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [BLOCK_W-1:0] rsp_block;
  logic              rsp_err;
  logic              mem_miss;
  logic [ADDR_W-1:0] mem_addr;
  logic [BLOCK_W-1:0] mem_block;
  logic              mem_write;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr, mem_block, mem_write,
    output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
           rsp_block, rsp_err, mem_miss, mem_addr
  );

  // Requesters plus memory side.
  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr, mem_block, mem_write,
    input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
           rsp_block, rsp_err, mem_miss, mem_addr
  );
endinterface

// File: rtl/refill_arbiter.sv
// Round-robin sequencer for the single main-memory refill port shared by
// the icache miss path (port 0) and the next-line prefetcher (port 1).
// One block access at a time, bounded by a timeout; a second request for
// the same block can piggy-back on the response cycle.
module refill_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 64,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             reset,
  refill_arbiter_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-3){1'b1}}, 3'b000};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state;
  logic               last_grant;
  logic               id;
  logic [ADDR_W-1:0]  addr_q;
  logic [BLOCK_W-1:0] block_q;
  logic               err_q;
  logic               miss_q;
  logic [CNT_W-1:0]   cnt;

  logic               any_valid;
  logic               win;
  logic [ADDR_W-1:0]  win_addr;
  logic               other_valid;
  logic [ADDR_W-1:0]  other_addr;
  logic               grant;
  logic               merge;
  logic               rsp_live;

  // Winner selection in IDLE and same-block merge detection in RESP.
  always_comb begin
    any_valid   = bus.req0_valid | bus.req1_valid;
    win         = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      win = ~last_grant;
    end else if (bus.req1_valid) begin
      win = 1'b1;
    end
    win_addr    = win ? bus.req1_addr : bus.req0_addr;
    other_valid = id ? bus.req0_valid : bus.req1_valid;
    other_addr  = id ? bus.req0_addr  : bus.req1_addr;
    grant       = (state == S_IDLE) && any_valid && !reset;
    merge       = (state == S_RESP) && other_valid && !err_q && !reset &&
                  ((other_addr & ALIGN_MASK) == addr_q);
    rsp_live    = (state == S_RESP) && !reset;
  end

  // ready/rsp_valid must answer a request in the cycle it is presented, so
  // they are decoded from the registered state rather than stored; reset
  // masks them so they drop immediately.
  always_comb begin
    bus.req0_ready = (grant && !win) || (merge && id);
    bus.req1_ready = (grant &&  win) || (merge && !id);
    bus.rsp0_valid = rsp_live && (!id || merge);
    bus.rsp1_valid = rsp_live && ( id || merge);
  end

  assign bus.rsp_block = block_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_miss  = miss_q;
  assign bus.mem_addr  = addr_q;

  // Access sequencer: grant, wait for the memory strobe or timeout, respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      id         <= 1'b0;
      addr_q     <= '0;
      block_q    <= '0;
      err_q      <= 1'b0;
      miss_q     <= 1'b0;
      cnt        <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_valid) begin
            id         <= win;
            last_grant <= win;
            addr_q     <= win_addr & ALIGN_MASK;
            miss_q     <= 1'b1;
            cnt        <= '0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.mem_write) begin
            block_q <= bus.mem_block;
            err_q   <= 1'b0;
            miss_q  <= 1'b0;
            state   <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            block_q <= '0;
            err_q   <= 1'b1;
            miss_q  <= 1'b0;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_refill_arbiter.sv
// Bench for refill_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level timeline model.
module tb_refill_arbiter;
  localparam int ADDR_W  = 32;
  localparam int BLOCK_W = 64;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  refill_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bif ();

  refill_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  int tests = 0;
  int fails = 0;

  // Requester-side pending requests and the model's remembered state.
  bit          pv [2];
  logic [31:0] pa [2];
  int          last_g;
  logic [31:0] prev_addr;
  logic [63:0] prev_blk;
  logic        prev_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string ctx, input logic r0, input logic r1,
                         input logic v0, input logic v1, input logic miss,
                         input logic [31:0] addr, input logic [63:0] blk, input logic err);
    chk({ctx, ".req0_ready"}, {63'd0, bif.req0_ready}, {63'd0, r0});
    chk({ctx, ".req1_ready"}, {63'd0, bif.req1_ready}, {63'd0, r1});
    chk({ctx, ".rsp0_valid"}, {63'd0, bif.rsp0_valid}, {63'd0, v0});
    chk({ctx, ".rsp1_valid"}, {63'd0, bif.rsp1_valid}, {63'd0, v1});
    chk({ctx, ".mem_miss"},   {63'd0, bif.mem_miss},   {63'd0, miss});
    chk({ctx, ".mem_addr"},   {32'd0, bif.mem_addr},   {32'd0, addr});
    chk({ctx, ".rsp_block"},  bif.rsp_block,           blk);
    chk({ctx, ".rsp_err"},    {63'd0, bif.rsp_err},    {63'd0, err});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    bif.req0_valid = pv[0];
    bif.req0_addr  = pa[0];
    bif.req1_valid = pv[1];
    bif.req1_addr  = pa[1];
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFF8;
  endfunction

  // One full access: accept in IDLE, `lat` cycles to the memory strobe
  // (no strobe if lat > TIMEOUT), then the response cycle.
  task automatic txn(input int lat, input logic [63:0] blk, input bit linger,
                     input bit idle_noise, input bit inj, input logic [31:0] inj_addr);
    int          win;
    int          other;
    int          ncyc;
    bit          err;
    bit          mrg;
    logic [31:0] la;
    logic [63:0] exp_blk;

    drive_reqs();
    bif.mem_write = idle_noise;
    bif.mem_block = {$urandom, $urandom};
    if (pv[0] && pv[1]) win = 1 - last_g;
    else if (pv[0])     win = 0;
    else                win = 1;
    other = 1 - win;
    @(negedge clk);
    chk_all("accept", win == 0, win == 1, 1'b0, 1'b0, 1'b0, prev_addr, prev_blk, prev_err);
    tick();

    la      = align(pa[win]);
    pv[win] = 1'b0;
    last_g  = win;
    drive_reqs();
    err  = (lat > TIMEOUT);
    ncyc = err ? TIMEOUT : lat;
    for (int k = 1; k <= ncyc; k++) begin
      if (k == 1 && inj && !pv[other]) begin
        pv[other] = 1'b1;
        pa[other] = inj_addr;
        drive_reqs();
      end
      if (!err && k == lat) begin
        bif.mem_write = 1'b1;
        bif.mem_block = blk;
      end else begin
        bif.mem_write = 1'b0;
        bif.mem_block = {$urandom, $urandom};
      end
      @(negedge clk);
      chk_all("wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, la, prev_blk, prev_err);
      tick();
    end

    bif.mem_write = linger;
    bif.mem_block = {$urandom, $urandom};
    mrg     = pv[other] && (align(pa[other]) == la) && !err;
    exp_blk = err ? 64'd0 : blk;
    @(negedge clk);
    chk_all("resp",
            (other == 0) && mrg, (other == 1) && mrg,
            (win == 0) || mrg, (win == 1) || mrg,
            1'b0, la, exp_blk, err);
    tick();

    if (mrg) pv[other] = 1'b0;
    drive_reqs();
    bif.mem_write = 1'b0;
    prev_addr = la;
    prev_blk  = exp_blk;
    prev_err  = err;
  endtask

  task automatic idle_cycle(input bit noise);
    drive_reqs();
    bif.mem_write = noise;
    bif.mem_block = {$urandom, $urandom};
    @(negedge clk);
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, prev_addr, prev_blk, prev_err);
    tick();
    bif.mem_write = 1'b0;
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge even
  // with both requesters raising valid.
  task automatic do_reset();
    bif.req0_valid = 1'b1;
    bif.req1_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk_all("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    tick();
    @(negedge clk);
    chk_all("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    tick();
    reset     = 1'b0;
    pv[0]     = 1'b0;
    pv[1]     = 1'b0;
    last_g    = 1;
    prev_addr = '0;
    prev_blk  = '0;
    prev_err  = 1'b0;
    drive_reqs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] blk;
    int          lat;
    bit          lg;
    bit          nz;
    bit          ij;
    logic [31:0] ia;

    reset          = 1'b1;
    pv[0]          = 1'b0;
    pv[1]          = 1'b0;
    pa[0]          = '0;
    pa[1]          = '0;
    last_g         = 1;
    prev_addr      = '0;
    prev_blk       = '0;
    prev_err       = 1'b0;
    bif.mem_write  = 1'b0;
    bif.mem_block  = '0;
    drive_reqs();
    #2;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Single request, 9-cycle memory.
    pv[0] = 1'b1; pa[0] = 32'h0000_0013;
    txn(10, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 1'b0, 32'd0);

    // Simultaneous requests straight after reset: port 0 first.
    do_reset();
    pv[0] = 1'b1; pa[0] = 32'h20;
    pv[1] = 1'b1; pa[1] = 32'h40;
    txn(10, 64'hA0A0_0000_0000_0020, 1'b0, 1'b0, 1'b0, 32'd0);
    txn(10, 64'hB0B0_0000_0000_0040, 1'b0, 1'b0, 1'b0, 32'd0);

    // Continuous demand from both ports: alternating grants.
    for (int i = 0; i < 4; i++) begin
      if (!pv[0]) begin pv[0] = 1'b1; pa[0] = 32'h100 + 32'(i * 64); end
      if (!pv[1]) begin pv[1] = 1'b1; pa[1] = 32'h800 + 32'(i * 64); end
      txn(10, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 32'd0);
    end
    if (pv[0] || pv[1]) txn(10, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 32'd0);

    // Merge: prefetch of the same block arrives during WAIT.
    pv[0] = 1'b1; pa[0] = 32'h48;
    txn(10, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b0, 1'b1, 32'h4C);
    // Merge left last_grant at 0, so port 1 wins the next tie.
    pv[0] = 1'b1; pa[0] = 32'h300;
    pv[1] = 1'b1; pa[1] = 32'h340;
    txn(3, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 32'd0);
    txn(3, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 32'd0);

    // Timeout, then a stray strobe in IDLE.
    pv[0] = 1'b1; pa[0] = 32'h500;
    txn(TIMEOUT + 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Strobe on the last WAIT cycle beats the timeout; shortest latency.
    pv[1] = 1'b1; pa[1] = 32'h600;
    txn(TIMEOUT, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b0, 32'd0);
    pv[0] = 1'b1; pa[0] = 32'h700;
    txn(1, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Reset during WAIT: no response, next grant to port 0.
    pv[0] = 1'b1; pa[0] = 32'h234;
    drive_reqs();
    @(negedge clk);
    chk("midwait.accept", {63'd0, bif.req0_ready}, 64'd1);
    tick();
    pv[0] = 1'b0;
    drive_reqs();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk_all("midwait.wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h230, prev_blk, prev_err);
      tick();
    end
    do_reset();
    for (int k = 0; k < 12; k++) idle_cycle(1'b0);
    pv[0] = 1'b1; pa[0] = 32'h900;
    pv[1] = 1'b1; pa[1] = 32'hA00;
    txn(5, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 32'd0);
    txn(5, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 32'd0);

    // Randomized traffic over a small address pool to provoke merges.
    for (int n = 0; n < 60; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 2) != 0) begin
          pv[p] = 1'b1;
          pa[p] = 32'($urandom_range(0, 31));
        end
      end
      if (!pv[0] && !pv[1]) begin
        idle_cycle($urandom_range(0, 1) != 0);
      end else begin
        blk = {$urandom, $urandom};
        lat = int'($urandom_range(1, TIMEOUT + 2));
        lg  = ($urandom_range(0, 1) != 0);
        nz  = ($urandom_range(0, 1) != 0);
        ij  = ($urandom_range(0, 1) != 0);
        ia  = 32'($urandom_range(0, 31));
        txn(lat, blk, lg, nz, ij, ia);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (pv[0] || pv[1]) txn(4, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
